uart_rx: RTL and testbench
==========================

# uart_rx

Synthesizable UART receiver that deserializes the asynchronous serial line driven by the bench's UART transceiver (or an external host) into bytes for the SoC fabric. It runs entirely in the system clock domain, derives bit timing from a fixed clocks-per-bit divider, and presents each received byte through a one-entry valid/ready output buffer. It is the receive path instantiated inside `top` on `io_uart_rx`.

## Interface

- `CLOCKS_PER_BIT`, 868, system clocks per serial bit (100 MHz / 115200); must be >= 4
- `DATA_WIDTH`, 8, data bits per frame, LSB first
- `i_clock`  input  1  system clock; single clock domain
- `i_reset`  input  1  synchronous, active-high reset
- `i_uart_rx`  input  1  asynchronous serial line, idle high
- `o_data`  output  DATA_WIDTH  received byte; stable while `o_data_valid` is high
- `o_data_valid`  output  1  buffer holds an unconsumed byte
- `i_data_ready`  input  1  consumer accepts `o_data` when high with `o_data_valid`
- `o_frame_error`  output  1  one-cycle pulse: stop bit sampled low
- `o_overrun`  output  1  one-cycle pulse: frame completed while buffer full; new byte dropped
- `o_parity_error`  output  1  one-cycle pulse: parity mismatch (present only with `UART_RX_PARITY_EN`)

## Operation

- Input passes through a 2-flop synchronizer (reset to 1); all decisions use the synchronized value `rx_s`.
- Bit counter width `$clog2(CLOCKS_PER_BIT)`; data bit index width `$clog2(DATA_WIDTH)`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE: `rx_s == 0` -> START, clear counter.
  - START: after `CLOCKS_PER_BIT/2` cycles sample; `rx_s == 0` -> DATA; `rx_s == 1` (glitch) -> IDLE, no error.
  - DATA: every `CLOCKS_PER_BIT` cycles sample one bit into shift register, LSB first; after bit `DATA_WIDTH-1` -> PARITY (macro) or STOP.
  - PARITY: sample after `CLOCKS_PER_BIT` cycles; compare to even parity of data -> STOP.
  - STOP: sample after `CLOCKS_PER_BIT` cycles. `rx_s == 1`: commit frame, -> IDLE. `rx_s == 0`: pulse `o_frame_error`, discard byte, -> WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s == 1` (break condition), then -> IDLE.
- Commit: if buffer empty, or full and accepted this same cycle (`o_data_valid && i_data_ready`), load `o_data`, set `o_data_valid`. Otherwise keep old byte, pulse `o_overrun`.
- Handshake: `o_data_valid` clears the cycle after `o_data_valid && i_data_ready` unless a commit occurs that same cycle.
- Frame with parity error: byte is discarded (not committed), `o_parity_error` pulses at stop-bit sample.

## Timing

- Reset values: `o_data` = 0, `o_data_valid` = 0, all error pulses 0, FSM = IDLE, synchronizer = 1.
- Reset mid-frame: FSM returns to IDLE next cycle, partial byte and buffered byte lost; next falling edge starts a new frame.
- Line-to-detect latency: 2 cycles (synchronizer) + 1 cycle IDLE->START.
- Samples land at mid-bit: start at `CLOCKS_PER_BIT/2`, then each subsequent bit `CLOCKS_PER_BIT` later.
- `o_data_valid` rises the cycle after the stop-bit sample; error pulses are registered and occur in that same cycle.
- Back-to-back frames (stop bit immediately followed by start) are received without loss; IDLE re-arms directly after stop sample.

## Configuration

- `UART_RX_PARITY_EN`: defined -> frame is start + DATA_WIDTH + even parity + stop; PARITY state and `o_parity_error` port exist. Undefined -> 8N1 framing, no PARITY state, no `o_parity_error` port.

## Test plan

- CLOCKS_PER_BIT=16, send 0xA5 8N1, `i_data_ready`=1 -> `o_data`=0xA5, `o_data_valid` high one cycle, no errors.
- Send 0x3C then 0xC3 back-to-back, `i_data_ready`=0 -> `o_data` holds 0x3C, `o_overrun` pulses once at second stop sample; raising ready then yields valid cleared.
- Send 0x55 with stop bit held low for 3 bit times -> `o_frame_error` pulse, `o_data_valid` stays 0, next frame 0x12 received correctly after line returns high.
- Low glitch of 4 cycles on idle line -> returns to IDLE, no valid, no error pulses.
- Assert `i_reset` during bit 4 of a frame -> all outputs 0 next cycle; subsequent 0x81 received correctly.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (wrong) -> `o_parity_error` pulse, no valid; with parity 1 -> 0x07 delivered.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-entry valid/ready output buffer.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_frame_error,
    output logic                  o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic                  o_parity_error,
`endif
    output logic [2:0]            o_state_dbg
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  commit;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  par_err_q, par_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q && !i_data_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s_q != ^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_err_d = par_bad_q;
                    par_bad_d = 1'b0;
`endif
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        commit  = !par_bad_q;
`else
                        commit  = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A full buffer can still take the new byte if it is drained on this same edge.
        if (commit) begin
            if (!valid_q || i_data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= i_uart_rx;
            rx_s_q      <= rx_meta_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = valid_q;
    assign o_frame_error = frame_err_q;
    assign o_overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_error = par_err_q;
`endif
    assign o_state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor pops expected bytes
// from a queue on every accepted output and tallies the error pulses.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_uart_rx = 1'b1;
    logic          i_data_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          o_frame_error;
    logic          o_overrun;
    logic [2:0]    o_state_dbg;
`ifdef UART_RX_PARITY_EN
    logic          o_parity_error;
`endif

    int checks   = 0;
    int failures = 0;
    int valid_cyc = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int perr_cnt  = 0;
    logic bad_parity = 1'b0;
    logic [DW-1:0] exp_q[$];

    uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_uart_rx      (i_uart_rx),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .i_data_ready   (i_data_ready),
        .o_frame_error  (o_frame_error),
        .o_overrun      (o_overrun),
`ifdef UART_RX_PARITY_EN
        .o_parity_error (o_parity_error),
`endif
        .o_state_dbg    (o_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // drivers: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        i_uart_rx = v;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int stop_low_bits);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_parity);
`endif
        if (stop_low_bits > 0) begin
            i_uart_rx = 1'b0;
            repeat (stop_low_bits * CPB) tick();
        end
        send_bit(1'b1);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_data_valid) valid_cyc++;
            if (o_frame_error) ferr_cnt++;
            if (o_overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (o_parity_error) perr_cnt++;
`endif
            if (o_data_valid && i_data_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, o_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int v0;
        int f0;

        // reset state
        i_reset = 1'b1;
        repeat (3) tick();
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_valid", {31'd0, o_data_valid}, 32'd0);
        check("rst_ferr", {31'd0, o_frame_error}, 32'd0);
        check("rst_ovr", {31'd0, o_overrun}, 32'd0);
        check("rst_state", {29'd0, o_state_dbg}, 32'd0);
        i_reset = 1'b0;
        repeat (5) tick();

        // single 0xA5 with consumer ready
        i_data_ready = 1'b1;
        v0 = valid_cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0);
        repeat (20) tick();
        check("a5_drained", exp_q.size(), 32'd0);
        check("a5_valid_cycles", valid_cyc - v0, 32'd1);
        check("a5_ferr", ferr_cnt, 32'd0);
        check("a5_ovr", ovr_cnt, 32'd0);

        // back-to-back with consumer stalled: second byte overruns
        i_data_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 0);
        send_frame(8'hC3, 0);
        repeat (20) tick();
        check("ovr_valid", {31'd0, o_data_valid}, 32'd1);
        check("ovr_data_held", {24'd0, o_data}, 32'h3C);
        check("ovr_pulses", ovr_cnt, 32'd1);
        i_data_ready = 1'b1;
        repeat (3) tick();
        check("ovr_valid_cleared", {31'd0, o_data_valid}, 32'd0);
        check("ovr_drained", exp_q.size(), 32'd0);

        // 0x55 with stop held low for 3 bit times, then 0x12
        v0 = valid_cyc;
        send_frame(8'h55, 3);
        repeat (2 * CPB) tick();
        check("ferr_pulses", ferr_cnt, 32'd1);
        check("ferr_no_valid", valid_cyc - v0, 32'd0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 0);
        repeat (20) tick();
        check("after_ferr_drained", exp_q.size(), 32'd0);
        check("after_ferr_valid_cycles", valid_cyc - v0, 32'd1);

        // 4-cycle low glitch on the idle line
        v0 = valid_cyc;
        f0 = ferr_cnt + ovr_cnt + perr_cnt;
        i_uart_rx = 1'b0;
        repeat (4) tick();
        i_uart_rx = 1'b1;
        repeat (3 * CPB) tick();
        check("glitch_no_valid", valid_cyc - v0, 32'd0);
        check("glitch_no_err", ferr_cnt + ovr_cnt + perr_cnt, f0);
        check("glitch_idle", {29'd0, o_state_dbg}, 32'd0);

        // buffered byte plus a partial frame are both lost on reset
        i_data_ready = 1'b0;
        send_frame(8'h99, 0);
        repeat (10) tick();
        check("pre_rst_valid", {31'd0, o_data_valid}, 32'd1);
        check("pre_rst_data", {24'd0, o_data}, 32'h99);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i_uart_rx = 1'b1;
        repeat (CPB / 2) tick();
        i_reset = 1'b1;
        tick();
        check("midrst_valid", {31'd0, o_data_valid}, 32'd0);
        check("midrst_data", {24'd0, o_data}, 32'd0);
        check("midrst_ferr", {31'd0, o_frame_error}, 32'd0);
        check("midrst_state", {29'd0, o_state_dbg}, 32'd0);
        i_reset = 1'b0;
        repeat (2 * CPB) tick();
        i_data_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 0);
        repeat (20) tick();
        check("after_rst_drained", exp_q.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
        // wrong parity drops the byte, correct parity delivers it
        v0 = valid_cyc;
        bad_parity = 1'b1;
        send_frame(8'h07, 0);
        repeat (20) tick();
        check("perr_pulses", perr_cnt, 32'd1);
        check("perr_no_valid", valid_cyc - v0, 32'd0);
        bad_parity = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 0);
        repeat (20) tick();
        check("par_ok_drained", exp_q.size(), 32'd0);
        check("par_ok_perr", perr_cnt, 32'd1);
`endif

        check("final_ferr", ferr_cnt, 32'd1);
        check("final_ovr", ovr_cnt, 32'd1);
        check("final_queue", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
